// File: rtl/bcd_pkg.sv
// Shared decimal-arithmetic definitions for the BCD adder and subtractor.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bcd_sub_state_t;

  // A nibble above 9 is not a decimal digit.
  function automatic logic bcd_digit_invalid(bcd_digit_t x);
    return x > bcd_digit_t'(BCD_RADIX - 1);
  endfunction

endpackage

// File: rtl/bcd_seq_subtractor_if.sv
// Operand/result handshake bundle for the sequential BCD subtractor.
// The err signal exists only when BCD_CHECK_EN is defined.
interface bcd_seq_subtractor_if #(
  parameter int NDIGITS = 2
);
  import bcd_pkg::*;

  localparam int W = BCD_DIGIT_W * NDIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic [W-1:0] d;
  logic         bout;
  logic         done;
`ifdef BCD_CHECK_EN
  logic         err;
`endif

  modport master (
    output start, a, b, bin,
`ifdef BCD_CHECK_EN
    input  err,
`endif
    input  ready, d, bout, done
  );

  modport slave (
    input  start, a, b, bin,
`ifdef BCD_CHECK_EN
    output err,
`endif
    output ready, d, bout, done
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract with borrow; invalid flag only
// with BCD_CHECK_EN.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       brw_i,
`ifdef BCD_CHECK_EN
  output logic       invalid_o,
`endif
  output bcd_digit_t d_o,
  output logic       brw_o
);

  logic [BCD_DIGIT_W:0] t;

  // Bit 4 of the 5-bit difference is the sign; a negative digit folds back by +10.
  always_comb begin
    t     = {1'b0, a_i} - {1'b0, b_i} - {{BCD_DIGIT_W{1'b0}}, brw_i};
    brw_o = t[BCD_DIGIT_W];
    d_o   = t[BCD_DIGIT_W] ? (t[BCD_DIGIT_W-1:0] + bcd_digit_t'(BCD_RADIX))
                           : t[BCD_DIGIT_W-1:0];
  end

`ifdef BCD_CHECK_EN
  assign invalid_o = bcd_digit_invalid(a_i) | bcd_digit_invalid(b_i);
`endif

endmodule

// File: rtl/bcd_seq_subtractor.sv
// Sequential packed-BCD subtractor: D = A - B - bin, one digit per clock, LSD first.
// Optional digit-validity checking with err output under BCD_CHECK_EN.
module bcd_seq_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_seq_subtractor_if.slave bus
);

  localparam int W     = BCD_DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  bcd_sub_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;

  bcd_digit_t             dig;
  logic                   dig_brw;
  logic [W+BCD_DIGIT_W-1:0] acc_shift;

`ifdef BCD_CHECK_EN
  logic dig_invalid;
  logic err_run_q, err_run_d;
  logic err_q, err_d;
`endif

  bcd_digit_sub u_digit (
    .a_i       (a_q[BCD_DIGIT_W-1:0]),
    .b_i       (b_q[BCD_DIGIT_W-1:0]),
    .brw_i     (brw_q),
`ifdef BCD_CHECK_EN
    .invalid_o (dig_invalid),
`endif
    .d_o       (dig),
    .brw_o     (dig_brw)
  );

  // New digit enters at the top; after NDIGITS shifts digit 0 sits at [3:0].
  assign acc_shift = {dig, acc_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef BCD_CHECK_EN
    err_run_d = err_run_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
`ifdef BCD_CHECK_EN
          err_run_d = 1'b0;
          err_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        a_d   = a_q >> BCD_DIGIT_W;
        b_d   = b_q >> BCD_DIGIT_W;
        brw_d = dig_brw;
        acc_d = acc_shift[W+BCD_DIGIT_W-1:BCD_DIGIT_W];
        idx_d = idx_q + 1'b1;
`ifdef BCD_CHECK_EN
        err_run_d = err_run_q | dig_invalid;
`endif
        if (idx_q == LAST_IDX) begin
          d_d     = acc_shift[W+BCD_DIGIT_W-1:BCD_DIGIT_W];
          bout_d  = dig_brw;
          state_d = DONE;
`ifdef BCD_CHECK_EN
          err_d = err_run_q | dig_invalid;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef BCD_CHECK_EN
      err_run_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef BCD_CHECK_EN
      err_run_q <= err_run_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
`ifdef BCD_CHECK_EN
  assign bus.err   = err_q;
`endif

endmodule
